// File: rtl/aes_ctr_pkg.sv
// Shared types, the scheduler state enum and the counter-increment helper.
// CTR_INC32_EN selects a GCM-style 32-bit counter instead of the full 128-bit add.
package aes_ctr_pkg;

    localparam int AES_BLK_W = 128;

    typedef logic [127:0] block_t;
    typedef logic [255:0] key_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    function automatic block_t ctr_inc(input block_t c);
`ifdef CTR_INC32_EN
        // Only the low word counts; the nonce part keeps its IV value.
        ctr_inc = {c[127:32], c[31:0] + 32'd1};
`else
        ctr_inc = c + 128'd1;
`endif
    endfunction

endpackage

// File: rtl/aes_ctr_scheduler_ctr_block_xor.sv
// Result word register: clears on message acceptance, then takes one
// msg ^ keystream block per core completion at the slot chosen by idx_i.
module ctr_block_xor
    import aes_ctr_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3,
    parameter int MSG_W      = AES_BLK_W * NUM_BLOCKS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [MSG_W-1:0] msg_i,
    input  block_t           ks_i,
    output logic [MSG_W-1:0] res_o
);

    logic [MSG_W-1:0] res_q;
    logic [MSG_W-1:0] res_d;

    always_comb begin
        res_d = res_q;
        if (clr_i) begin
            res_d = '0;
        end else if (wr_i) begin
            // Block 0 lives in the most significant slice.
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                if (idx_i == IDX_W'(b)) begin
                    res_d[MSG_W-1-b*AES_BLK_W -: AES_BLK_W] =
                        msg_i[MSG_W-1-b*AES_BLK_W -: AES_BLK_W] ^ ks_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/aes_ctr_scheduler.sv
// AES-256-CTR sequencer: issues one counter block per message block to a shared
// iterative core and assembles the XOR result. CTR_INC32_EN selects a 32-bit counter.
module aes_ctr_scheduler
    import aes_ctr_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int MSG_W      = AES_BLK_W * NUM_BLOCKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] msg_in,
    input  logic [255:0]     key,
    input  logic [127:0]     iv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] msg_out,
    output logic             busy,
    output logic             core_start,
    output logic [255:0]     core_key,
    output logic [127:0]     core_in,
    input  logic             core_done,
    input  logic [127:0]     core_out
);

    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    sched_state_e     state_q;
    logic [MSG_W-1:0] msg_q;
    key_t             key_q;
    block_t           ctr_q;
    block_t           core_in_q;
    logic [IDX_W-1:0] idx_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             core_start_q;

    logic res_clr;
    logic res_wr;

    // A done pulse only counts while waiting on the core; ISSUE-cycle pulses are dropped.
    assign res_clr = (state_q == IDLE) && in_valid;
    assign res_wr  = (state_q == WAIT) && core_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            msg_q        <= '0;
            key_q        <= '0;
            ctr_q        <= '0;
            core_in_q    <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        msg_q        <= msg_in;
                        key_q        <= key;
                        ctr_q        <= iv;
                        core_in_q    <= iv;
                        idx_q        <= '0;
                        core_start_q <= 1'b1;
                        in_ready_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        ctr_q <= ctr_inc(ctr_q);
                        if (idx_q == LAST_IDX) begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            // Outputs are registered, so the next ISSUE values are set here.
                            idx_q        <= idx_q + IDX_W'(1);
                            core_in_q    <= ctr_inc(ctr_q);
                            core_start_q <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ctr_block_xor #(
        .NUM_BLOCKS(NUM_BLOCKS),
        .IDX_W     (IDX_W),
        .MSG_W     (MSG_W)
    ) u_block_xor (
        .clk_i (clk),
        .rst_ni(rst),
        .clr_i (res_clr),
        .wr_i  (res_wr),
        .idx_i (idx_q),
        .msg_i (msg_q),
        .ks_i  (core_out),
        .res_o (msg_out)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign core_start = core_start_q;
    assign core_key   = key_q;
    assign core_in    = core_in_q;

endmodule

// File: tb/tb_aes_ctr_scheduler.sv
// Bench for aes_ctr_scheduler: stand-in AES core with fixed latency, a
// message-level reference model compared every cycle, and directed scenarios.
module tb_aes_ctr_scheduler;

  localparam int NB  = 8;
  localparam int L   = 3;
  localparam int W   = 128 * NB;
  localparam int LAT = NB * (2 + L);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           core_done = 1'b0;
  logic [W-1:0]   msg_in = '0;
  logic [255:0]   key = '0;
  logic [127:0]   iv = '0;
  logic [127:0]   core_out = '0;
  logic           in_ready, out_valid, busy, core_start;
  logic [W-1:0]   msg_out;
  logic [255:0]   core_key;
  logic [127:0]   core_in;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int core_mode = 0;
  bit stray_req = 1'b0;
  logic [127:0] stray_data = '0;

  // clock/reset block
  always #5 clk = ~clk;

  aes_ctr_scheduler #(.NUM_BLOCKS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msg_in    (msg_in),
    .key       (key),
    .iv        (iv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .msg_out   (msg_out),
    .busy      (busy),
    .core_start(core_start),
    .core_key  (core_key),
    .core_in   (core_in),
    .core_done (core_done),
    .core_out  (core_out)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // counter value for block i, straight from the increment rule
  function automatic logic [127:0] ctr_at(input logic [127:0] base, input int i);
`ifdef CTR_INC32_EN
    ctr_at = {base[127:32], base[31:0] + 32'(i)};
`else
    ctr_at = base + 128'(i);
`endif
  endfunction

  // stand-in block cipher: identity, or a keyed mix for round-trip runs
  function automatic logic [127:0] ks(input logic [127:0] ci, input logic [255:0] k, input int mode);
    if (mode == 0) ks = ci;
    else ks = {ci[94:0], ci[127:95]} ^ k[255:128] ^ {k[63:0], k[127:64]}
              ^ 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
  endfunction

  function automatic logic [W-1:0] expect_msg(input logic [W-1:0] m, input logic [255:0] k,
                                               input logic [127:0] v, input int mode);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[W-1-i*128 -: 128] = m[W-1-i*128 -: 128] ^ ks(ctr_at(v, i), k, mode);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_msg();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // core model: done returned L edges after the edge that saw core_start
  bit pend = 1'b0;
  int pend_cnt = 0;
  logic [127:0] pend_data = '0;

  always begin : core_model
    logic s, r, fire;
    logic [127:0] ci, fdata;
    logic [255:0] ck;
    int md;
    @(negedge clk);
    s = core_start; r = rst; ci = core_in; ck = core_key; md = core_mode;
    @(posedge clk);
    #2;
    fire = 1'b0;
    fdata = '0;
    if (!r) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          fire = 1'b1; fdata = pend_data; pend = 1'b0;
        end
      end
      if (s === 1'b1) begin
        if (mon_en) chk("core_idle_at_start", 256'(pend), 256'(0));
        pend = 1'b1; pend_cnt = L; pend_data = ks(ci, ck, md);
      end
    end
    if (stray_req) begin
      core_done = 1'b1; core_out = stray_data; stray_req = 1'b0;
    end else begin
      core_done = fire;
      core_out = fire ? fdata : {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  end

  // scoreboard: message-level phases plus expected results
  int ph = 0;
  int cnt = 0;
  int starts = 0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] mon_exp;
  logic [255:0] m_key = '0;
  logic [127:0] m_iv = '0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      case (ph)
        0: begin
          chk("idle_in_ready", 256'(in_ready), 256'(1));
          chk("idle_out_valid", 256'(out_valid), 256'(0));
          chk("idle_busy", 256'(busy), 256'(0));
          chk("idle_core_start", 256'(core_start), 256'(0));
          for (int b = 0; b < NB; b++)
            chk("idle_msg_out", 256'(msg_out[W-1-b*128 -: 128]), 256'(m_out[W-1-b*128 -: 128]));
        end
        1: begin
          chk("run_in_ready", 256'(in_ready), 256'(0));
          chk("run_out_valid", 256'(out_valid), 256'(0));
          chk("run_busy", 256'(busy), 256'(1));
          chk("run_core_key", core_key, m_key);
          if (core_start === 1'b1) begin
            chk("start_in_range", 256'(starts < NB), 256'(1));
            chk("core_in_ctr", 256'(core_in), 256'(ctr_at(m_iv, starts)));
            starts++;
          end
        end
        default: begin
          mon_exp = (exp_q.size() > 0) ? exp_q[0] : '0;
          chk("done_out_valid", 256'(out_valid), 256'(1));
          chk("done_in_ready", 256'(in_ready), 256'(0));
          chk("done_busy", 256'(busy), 256'(1));
          chk("done_core_start", 256'(core_start), 256'(0));
          for (int b = 0; b < NB; b++)
            chk("done_msg_out", 256'(msg_out[W-1-b*128 -: 128]), 256'(mon_exp[W-1-b*128 -: 128]));
        end
      endcase
      if (!rst) begin
        ph = 0; m_out = '0; exp_q.delete();
      end else begin
        case (ph)
          0: if (in_valid) begin
            ph = 1; cnt = 0; starts = 0; m_key = key; m_iv = iv;
            exp_q.push_back(expect_msg(msg_in, key, iv, core_mode));
          end
          1: begin
            cnt++;
            if (cnt == LAT) begin
              ph = 2;
              chk("start_count", 256'(starts), 256'(NB));
            end
          end
          default: if (out_ready && exp_q.size() > 0) begin
            m_out = exp_q.pop_front(); ph = 0;
          end
        endcase
      end
    end
  end

  // driver tasks (called at posedge + #1)
  task automatic send(input logic [W-1:0] m, input logic [255:0] k, input logic [127:0] v, input bit stray);
    bit ok;
    ok = 1'b0;
    msg_in = m; key = k; iv = v; in_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 256'(ok), 256'(1));
    msg_in = rand_msg();
    key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    iv = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (stray) begin
      stray_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      stray_req = 1'b1;
    end
  endtask

  task automatic recv(input int hold, output logic [W-1:0] res, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      lat++;
      got = (out_valid === 1'b1);
    end
    chk("done_timeout", 256'(got), 256'(1));
    res = msg_out;
    if (out_ready) begin
      @(posedge clk);
      #1 out_ready = 1'b0;
    end else begin
      repeat (hold + 1) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2000000;
    bad++;
    $display("FAIL watchdog: got no end of run expected finish before time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    logic [W-1:0] r1, pt, ct, pt2;
    logic [127:0] e128;
    logic [255:0] rt_key;
    logic [127:0] rt_iv;
    int lat;
    bit polled;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_core_start", 256'(core_start), 256'(0));
    chk("rst_msg_out_zero", 256'(msg_out == '0), 256'(1));
    chk("rst_core_key", core_key, 256'(0));
    chk("rst_core_in", 256'(core_in), 256'(0));
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;

    // counter sequencing: blocks are just the counter values 0..7
    core_mode = 0;
    send('0, 256'h1234, 128'h0, 1'b0);
    recv(0, r1, lat);
    chk("latency", 256'(lat - 1), 256'(LAT));
    for (int i = 0; i < NB; i++) begin
      e128 = 128'(i);
      chk("seq_block", 256'(r1[W-1-i*128 -: 128]), 256'(e128));
    end

    // counter wrap
    send('0, 256'h0, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe, 1'b0);
    recv(2, r1, lat);
    chk("wrap_b0", 256'(r1[W-1 -: 128]), 256'(128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe));
    chk("wrap_b1", 256'(r1[W-129 -: 128]), 256'(128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff));
`ifdef CTR_INC32_EN
    chk("wrap_b2", 256'(r1[W-257 -: 128]), 256'(128'hffff_ffff_ffff_ffff_ffff_ffff_0000_0000));
    chk("wrap_b3", 256'(r1[W-385 -: 128]), 256'(128'hffff_ffff_ffff_ffff_ffff_ffff_0000_0001));
`else
    chk("wrap_b2", 256'(r1[W-257 -: 128]), 256'(128'h0));
    chk("wrap_b3", 256'(r1[W-385 -: 128]), 256'(128'h1));
`endif

    // backpressure in DONE for 20 cycles
    send(rand_msg(), 256'h0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    recv(20, r1, lat);

    // out_ready held high early, stray done during ISSUE
    core_mode = 1;
    send(rand_msg(), {8{$urandom()}}, {$urandom(), $urandom(), $urandom(), 32'hffff_fffd}, 1'b1);
    out_ready = 1'b1;
    recv(0, r1, lat);

    // randomized messages
    for (int n = 0; n < 6; n++) begin
      core_mode = int'($urandom_range(0, 1));
      e128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0) e128[31:0] = 32'hffff_fffc;
      send(rand_msg(), {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()}, e128,
           bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) out_ready = 1'b1;
      recv(int'($urandom_range(0, 5)), r1, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // reset during WAIT of block 3, then a stray done
    core_mode = 0;
    send(rand_msg(), 256'h55, 128'h100, 1'b0);
    polled = 1'b0;
    for (int t = 0; t < 200 && !polled; t++) begin
      @(negedge clk);
      #1;
      polled = (starts >= 4);
    end
    chk("reach_block3", 256'(polled), 256'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stray_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    stray_req = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("after_rst_in_ready", 256'(in_ready), 256'(1));
    chk("after_rst_out_valid", 256'(out_valid), 256'(0));
    chk("after_rst_msg_out_zero", 256'(msg_out == '0), 256'(1));
    @(posedge clk);
    #1;

    // round trip with the keyed stand-in core
    core_mode = 1;
    rt_key = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    rt_iv = 128'hffeeddccbbaa99887766554433221100;
    pt = rand_msg();
    send(pt, rt_key, rt_iv, 1'b0);
    recv(1, ct, lat);
    chk("ct_differs", 256'(ct == pt), 256'(0));
    send(ct, rt_key, rt_iv, 1'b0);
    recv(1, pt2, lat);
    for (int i = 0; i < NB; i++)
      chk("round_trip", 256'(pt2[W-1-i*128 -: 128]), 256'(pt[W-1-i*128 -: 128]));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
